// File: rtl/link_pkg.sv
// Shared widths, grant codes, FSM state type and key payload encoding
// for the link transmit scheduler.
package link_pkg;

    localparam int KEY_W     = 5;
    localparam int PAYLOAD_W = 16;
    localparam int FRAME_W   = 49;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_KEY  = 2'b01;
    localparam logic [1:0] GRANT_GAME = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Key vector K becomes the 16-bit payload {K, ~K, K, ~^K}.
    function automatic logic [PAYLOAD_W-1:0] encode_key(input logic [KEY_W-1:0] k);
        return {k, ~k, k, ~^k};
    endfunction

endpackage

// File: rtl/link_frame_encoder.sv
// Combinational frame builder: payload P -> {P, ~P, P, ~^P}.
module link_frame_encoder
    import link_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] payload,
    output logic [FRAME_W-1:0]   frame
);

    assign frame = {payload, ~payload, payload, ~^payload};

endmodule

// File: rtl/link_tx_scheduler.sv
// Two-requester (key / game-state) frame scheduler feeding a serial transmitter.
// Define LINK_KEY_REPEAT_EN to resend the last key vector as a keepalive.
module link_tx_scheduler
    import link_pkg::*;
#(
    parameter int BUSY_TIMEOUT  = 8,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic        LINK_CLK,
    input  logic        RST,
    input  logic        KEY_VALID,
    input  logic [0:4]  KEY_IN,
    input  logic        GAME_VALID,
    input  logic [0:15] GAME_IN,
    input  logic        TR_READY,
    output logic        TX_START,
    output logic [0:48] TX_DATA,
    output logic [1:0]  GRANT,
    output logic [7:0]  OVERRUN_CNT
);

    localparam int BCW = $clog2(BUSY_TIMEOUT + 1);

    state_t               state, state_next;
    logic [PAYLOAD_W-1:0] key_slot, game_slot, sel_payload;
    logic [FRAME_W-1:0]   frame;
    logic                 key_pend, game_pend, rr_key_first;
    logic                 launch, grant_key, grant_game;
    logic                 busy_expired, tx_done;
    logic                 key_take, game_take, key_retry, game_retry, key_repeat;
    logic                 key_ovr, game_ovr;
    logic [8:0]           ovr_sum;
    logic [BCW-1:0]       busy_cnt;

    // Round-robin: on a tie the requester not granted last wins.
    assign grant_key    = key_pend && (!game_pend || rr_key_first);
    assign grant_game   = game_pend && !grant_key;
    assign launch       = (state == IDLE) && TR_READY && (key_pend || game_pend);
    assign busy_expired = (state == WAIT_BUSY) && TR_READY
                          && (busy_cnt == BCW'(BUSY_TIMEOUT - 1));
    assign tx_done      = (state == WAIT_DONE) && TR_READY;

    assign key_take   = launch && grant_key;
    assign game_take  = launch && grant_game;
    assign key_retry  = busy_expired && (GRANT == GRANT_KEY);
    assign game_retry = busy_expired && (GRANT == GRANT_GAME);

    // A slot captured into TX_DATA on this edge is no longer "not yet granted".
    assign key_ovr  = KEY_VALID && key_pend && !key_take;
    assign game_ovr = GAME_VALID && game_pend && !game_take;
    assign ovr_sum  = {1'b0, OVERRUN_CNT} + {8'd0, key_ovr} + {8'd0, game_ovr};

    assign sel_payload = grant_key ? key_slot : game_slot;

    link_frame_encoder u_encoder (
        .payload(sel_payload),
        .frame  (frame)
    );

    always_ff @(posedge LINK_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_next unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:      if (launch) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!TR_READY)         state_next = WAIT_DONE;
                else if (busy_expired) state_next = IDLE;
            end
            WAIT_DONE: if (TR_READY) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        TX_START = (state == START);
    end

    always_ff @(posedge LINK_CLK) begin
        if (RST || state != WAIT_BUSY) busy_cnt <= '0;
        else                           busy_cnt <= busy_cnt + 1'b1;
    end

    // Pending flag drops as the slot is captured into TX_DATA; a VALID on the same
    // edge (or any later one) re-arms it with the new contents.
    always_ff @(posedge LINK_CLK) begin
        if (RST) begin
            key_slot    <= '0;
            game_slot   <= '0;
            key_pend    <= 1'b0;
            game_pend   <= 1'b0;
            OVERRUN_CNT <= '0;
        end else begin
            if (KEY_VALID)  key_slot  <= encode_key(KEY_IN);
            if (GAME_VALID) game_slot <= GAME_IN;

            if (KEY_VALID || key_retry || key_repeat) key_pend <= 1'b1;
            else if (key_take)                        key_pend <= 1'b0;

            if (GAME_VALID || game_retry) game_pend <= 1'b1;
            else if (game_take)           game_pend <= 1'b0;

            OVERRUN_CNT <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
        end
    end

    always_ff @(posedge LINK_CLK) begin
        if (RST) begin
            TX_DATA      <= '0;
            GRANT        <= GRANT_NONE;
            rr_key_first <= 1'b1;
        end else if (launch) begin
            TX_DATA      <= frame;
            GRANT        <= grant_key ? GRANT_KEY : GRANT_GAME;
            rr_key_first <= grant_game;
        end else if (tx_done || busy_expired) begin
            GRANT <= GRANT_NONE;
        end
    end

`ifdef LINK_KEY_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_PERIOD + 1);

    logic [RCW-1:0] rep_cnt;
    logic           rep_hit;

    assign rep_hit    = (rep_cnt == RCW'(REPEAT_PERIOD - 1));
    assign key_repeat = rep_hit && !KEY_VALID && !key_take;

    always_ff @(posedge LINK_CLK) begin
        if (RST || KEY_VALID || key_take || rep_hit) rep_cnt <= '0;
        else                                         rep_cnt <= rep_cnt + 1'b1;
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Scoreboard bench for link_tx_scheduler: expected frames are queued as stimulus
// is driven and compared whenever TX_START pulses.
`timescale 1ns/1ps
module tb_link_tx_scheduler;

    localparam int BUSY_TIMEOUT  = 8;
    localparam int REPEAT_PERIOD = 20;

    typedef struct packed {
        logic [1:0]  grant;
        logic [48:0] data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [0:4]  key_in;
    logic        game_valid;
    logic [0:15] game_in;
    logic        tr_ready;
    logic        tx_start;
    logic [0:48] tx_data;
    logic [1:0]  grant;
    logic [7:0]  overrun_cnt;

    frame_t sb[$];
    int     n_vec   = 0;
    int     n_err   = 0;
    int     starts  = 0;
    int     exp_ovr = 0;
    logic   prev_start = 1'b0;

    link_tx_scheduler #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .LINK_CLK   (clk),
        .RST        (rst),
        .KEY_VALID  (key_valid),
        .KEY_IN     (key_in),
        .GAME_VALID (game_valid),
        .GAME_IN    (game_in),
        .TR_READY   (tr_ready),
        .TX_START   (tx_start),
        .TX_DATA    (tx_data),
        .GRANT      (grant),
        .OVERRUN_CNT(overrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] key_payload(input logic [4:0] k);
        return {k, ~k, k, ~^k};
    endfunction

    function automatic frame_t mk(input logic [1:0] g, input logic [15:0] p);
        frame_t f;
        f.grant = g;
        f.data  = {p, ~p, p, ~^p};
        return f;
    endfunction

    // Frame monitor: each TX_START rising pulse pops one expected frame.
    always @(negedge clk) begin : monitor
        frame_t exp;
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (prev_start === 1'b1) begin
                n_vec++;
                if (tx_start !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_width: TX_START=%b required 0", tx_start);
                end
            end else if (tx_start === 1'b1) begin
                starts++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame: GRANT=%b TX_DATA=%h required none",
                             grant, tx_data);
                end else begin
                    exp = sb.pop_front();
                    if (grant !== exp.grant || tx_data !== exp.data) begin
                        n_err++;
                        $display("FAIL frame: GRANT=%b TX_DATA=%h required GRANT=%b TX_DATA=%h",
                                 grant, tx_data, exp.grant, exp.data);
                    end
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        key_valid  = 1'b0;
        game_valid = 1'b0;
        tr_ready   = 1'b1;
        tick(2);
        rst = 1'b0;
        sb.delete();
        exp_ovr = 0;
    endtask

    task automatic pulse_key(input logic [4:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
    endtask

    task automatic pulse_game(input logic [15:0] g);
        game_in    = g;
        game_valid = 1'b1;
        tick(1);
        game_valid = 1'b0;
    endtask

    task automatic wait_start(input string what, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s_timeout: no TX_START within %0d cycles", what, limit);
        end
    endtask

    // Called on the negedge inside the START cycle: transmitter busy, then idle.
    task automatic serve(input string what, input int busy);
        tr_ready = 1'b0;
        tick(busy + 1);
        tr_ready = 1'b1;
        tick(1);
        n_vec++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL %s_grant_clear: GRANT=%b required 00", what, grant);
        end
    endtask

    task automatic run_frame(input string what, input int busy);
        bit f;
        wait_start(what, 12, f);
        if (f) serve(what, busy);
    endtask

    task automatic test_reset;
        int s0;
        rst        = 1'b1;
        key_valid  = 1'b1;
        key_in     = 5'b11011;
        game_valid = 1'b0;
        tr_ready   = 1'b1;
        tick(3);
        n_vec += 4;
        if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_start: %b required 0", tx_start); end
        if (tx_data !== '0) begin n_err++; $display("FAIL rst_data: %h required 0", tx_data); end
        if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: %b required 00", grant); end
        if (overrun_cnt !== 8'd0) begin
            n_err++; $display("FAIL rst_overrun: %0d required 0", overrun_cnt);
        end
        rst       = 1'b0;
        key_valid = 1'b0;
        s0 = starts;
        tick(6);
        n_vec++;
        if (starts != s0) begin
            n_err++; $display("FAIL rst_valid_ignored: %0d frames required 0", starts - s0);
        end
    endtask

    task automatic test_key_frame;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b10100)));
        key_in    = 5'b10100;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        n_vec++;
        if (tx_start !== 1'b0) begin
            n_err++; $display("FAIL key_latency_early: TX_START=%b required 0", tx_start);
        end
        tick(1);
        n_vec += 3;
        if (tx_start !== 1'b1) begin
            n_err++; $display("FAIL key_latency: TX_START=%b required 1", tx_start);
        end
        if (grant !== 2'b01) begin n_err++; $display("FAIL key_grant: %b required 01", grant); end
        if (tx_data[0:15] !== 16'b1010001011101001) begin
            n_err++;
            $display("FAIL key_payload: %b required 1010001011101001", tx_data[0:15]);
        end
        serve("key", 3);
    endtask

    task automatic test_simultaneous;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b01101)));
        sb.push_back(mk(2'b10, 16'hA5C3));
        key_in     = 5'b01101;
        game_in    = 16'hA5C3;
        key_valid  = 1'b1;
        game_valid = 1'b1;
        tick(1);
        key_valid  = 1'b0;
        game_valid = 1'b0;
        run_frame("both_key", 3);
        run_frame("both_game", 2);
        n_vec++;
        if (overrun_cnt !== 8'd0) begin
            n_err++; $display("FAIL both_overrun: %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b00011)));
        pulse_key(5'b00011);
        run_frame("rr_first", 1);
        sb.push_back(mk(2'b10, 16'h1234));
        sb.push_back(mk(2'b01, key_payload(5'b11000)));
        key_in     = 5'b11000;
        game_in    = 16'h1234;
        key_valid  = 1'b1;
        game_valid = 1'b1;
        tick(1);
        key_valid  = 1'b0;
        game_valid = 1'b0;
        run_frame("rr_game", 1);
        run_frame("rr_key", 1);
    endtask

    task automatic test_overrun;
        int s0;
        logic [15:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        tr_ready = 1'b0;
        s0 = starts;
        foreach (words[i]) begin
            if (i == 0) begin
                sb.push_back(mk(2'b10, words[i]));
            end else begin
                sb[$] = mk(2'b10, words[i]);
                exp_ovr++;
            end
            pulse_game(words[i]);
            tick(1);
        end
        n_vec++;
        if (overrun_cnt !== 8'(exp_ovr)) begin
            n_err++; $display("FAIL overrun_count: %0d required %0d", overrun_cnt, exp_ovr);
        end
        tr_ready = 1'b1;
        run_frame("overrun", 2);
        tick(10);
        n_vec++;
        if (starts - s0 != 1) begin
            n_err++; $display("FAIL overrun_frames: %0d required 1", starts - s0);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        tr_ready  = 1'b0;
        key_valid = 1'b1;
        for (int i = 0; i < 258; i++) begin
            key_in = 5'(i);
            if (i == 0) sb.push_back(mk(2'b01, key_payload(5'(i))));
            else begin
                sb[$] = mk(2'b01, key_payload(5'(i)));
                if (exp_ovr < 255) exp_ovr++;
            end
            tick(1);
        end
        key_valid = 1'b0;
        tick(1);
        n_vec++;
        if (overrun_cnt !== 8'(exp_ovr)) begin
            n_err++; $display("FAIL overrun_saturate: %0d required %0d", overrun_cnt, exp_ovr);
        end
        tr_ready = 1'b1;
        run_frame("saturate", 1);
    endtask

    task automatic test_inflight;
        bit f;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b10001)));
        pulse_key(5'b10001);
        wait_start("inflight_a", 6, f);
        tr_ready = 1'b0;
        tick(2);
        sb.push_back(mk(2'b01, key_payload(5'b01110)));
        pulse_key(5'b01110);
        tick(1);
        tr_ready = 1'b1;
        tick(1);
        n_vec++;
        if (grant !== 2'b00) begin
            n_err++; $display("FAIL inflight_grant_clear: %b required 00", grant);
        end
        run_frame("inflight_b", 2);
        n_vec++;
        if (overrun_cnt !== 8'd0) begin
            n_err++; $display("FAIL inflight_overrun: %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_timeout;
        bit f;
        int cyc;
        do_reset();
        sb.push_back(mk(2'b10, 16'hBEEF));
        sb.push_back(mk(2'b10, 16'hBEEF));
        pulse_game(16'hBEEF);
        wait_start("timeout_first", 6, f);
        cyc = 0;
        f   = 1'b0;
        while (cyc < 20 && !f) begin
            tick(1);
            cyc++;
            if (tx_start === 1'b1) f = 1'b1;
        end
        n_vec++;
        if (!f || cyc != BUSY_TIMEOUT + 2) begin
            n_err++;
            $display("FAIL timeout_retry_gap: %0d cycles (seen=%b) required %0d",
                     cyc, f, BUSY_TIMEOUT + 2);
        end
        if (f) serve("timeout_retry", 2);
        tick(15);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL timeout_pending: %0d frames outstanding required 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight;
        bit f;
        int s0;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b11111)));
        pulse_key(5'b11111);
        wait_start("midflight", 6, f);
        tr_ready = 1'b0;
        tick(1);
        pulse_game(16'h0F0F);
        pulse_game(16'hF0F0);
        n_vec++;
        if (overrun_cnt !== 8'd1) begin
            n_err++; $display("FAIL midflight_overrun: %0d required 1", overrun_cnt);
        end
        rst = 1'b1;
        tick(1);
        n_vec += 4;
        if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_start: %b required 0", tx_start); end
        if (tx_data !== '0) begin n_err++; $display("FAIL mid_rst_data: %h required 0", tx_data); end
        if (grant !== 2'b00) begin n_err++; $display("FAIL mid_rst_grant: %b required 00", grant); end
        if (overrun_cnt !== 8'd0) begin
            n_err++; $display("FAIL mid_rst_overrun: %0d required 0", overrun_cnt);
        end
        rst      = 1'b0;
        tr_ready = 1'b1;
        s0 = starts;
        tick(20);
        n_vec++;
        if (starts != s0) begin
            n_err++; $display("FAIL mid_rst_no_retry: %0d frames required 0", starts - s0);
        end
    endtask

    task automatic test_repeat;
        int s0;
        do_reset();
        sb.push_back(mk(2'b01, key_payload(5'b01010)));
        pulse_key(5'b01010);
        run_frame("repeat_first", 2);
        s0 = starts;
`ifdef LINK_KEY_REPEAT_EN
        sb.push_back(mk(2'b01, key_payload(5'b01010)));
        run_frame("repeat_keepalive", 2);
`else
        tick(3 * REPEAT_PERIOD);
        n_vec++;
        if (starts != s0) begin
            n_err++; $display("FAIL repeat_absent: %0d frames required 0", starts - s0);
        end
`endif
    endtask

    initial begin : main
        test_reset();
        test_key_frame();
        test_simultaneous();
        test_round_robin();
        test_overrun();
        test_saturation();
        test_inflight();
        test_timeout();
        test_reset_midflight();
        test_repeat();
        tick(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL final_scoreboard: %0d frames outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
